// File: rtl/range_tracker_pkg.sv
// Shared types for the range tracker: FSM state encoding and error causes.
package range_tracker_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RECEIVING = 2'd1,
    S_DONE      = 2'd2,
    S_ERROR     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,  // no error
    ERR_GOFIN  = 2'd1,  // go and finish in the same cycle
    ERR_NOSESS = 2'd2,  // finish with no open session
    ERR_OVF    = 2'd3   // sample counter would wrap
  } err_t;

endpackage : range_tracker_pkg

// File: rtl/minmax_update.sv
// Combinational min/max fold of one sample into a running extreme pair.
module minmax_update #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] i_max,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_sample,
  output logic [WIDTH-1:0] o_max,
  output logic [WIDTH-1:0] o_min
);

  logic w_above_max;
  logic w_below_min;

  // Compare the sample against both extremes and keep whichever wins.
  always_comb begin
    if (SIGNED) begin
      w_above_max = $signed(i_sample) > $signed(i_max);
      w_below_min = $signed(i_sample) < $signed(i_min);
    end else begin
      w_above_max = i_sample > i_max;
      w_below_min = i_sample < i_min;
    end
    o_max = w_above_max ? i_sample : i_max;
    o_min = w_below_min ? i_sample : i_min;
  end

endmodule : minmax_update

// File: rtl/range_tracker.sv
// Session min/max tracker: frames samples between go and finish, then
// publishes registered max, min, range and count with a one-cycle done pulse.
module range_tracker
  import range_tracker_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED    = 1'b0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 go,
  input  logic                 finish,
  input  logic                 valid_in,
  output logic [WIDTH-1:0]     max_out,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     range,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 done,
  output logic                 busy,
  output logic                 error,
  output logic [1:0]           err_code
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t r_state, w_state_nxt;
  err_t   r_err,   w_err_nxt;

  logic [WIDTH-1:0]     r_wmax, r_wmin;
  logic [CNT_WIDTH-1:0] r_wcnt;

  logic [WIDTH-1:0]     r_max_out, r_min_out, r_range;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_done, r_busy, r_error;

  logic                 w_load_first;  // (re)start the working set from data_in
  logic                 w_fold;        // count data_in into the working set
  logic                 w_publish;     // copy the working set to the outputs
  logic [WIDTH-1:0]     w_upd_max, w_upd_min;
  logic [WIDTH-1:0]     w_fin_max, w_fin_min;
  logic [CNT_WIDTH-1:0] w_fin_cnt;

  // Single fold unit, shared by in-session samples and the finish-cycle sample.
  minmax_update #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_minmax (
    .i_max    (r_wmax),
    .i_min    (r_wmin),
    .i_sample (data_in),
    .o_max    (w_upd_max),
    .o_min    (w_upd_min)
  );

  // Next-state, error cause and datapath control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt  = r_state;
    w_err_nxt    = r_err;
    w_load_first = 1'b0;
    w_fold       = 1'b0;
    w_publish    = 1'b0;

    if (go && finish) begin
      w_state_nxt = S_ERROR;
      w_err_nxt   = ERR_GOFIN;
    end else if (go) begin
      w_state_nxt  = S_RECEIVING;
      w_err_nxt    = ERR_NONE;
      w_load_first = 1'b1;
    end else if (finish) begin
      if (r_state != S_RECEIVING) begin
        w_state_nxt = S_ERROR;
        w_err_nxt   = ERR_NOSESS;
      end else if (valid_in && (r_wcnt == CNT_MAX)) begin
        w_state_nxt = S_ERROR;
        w_err_nxt   = ERR_OVF;
      end else begin
        w_fold      = valid_in;
        w_publish   = 1'b1;
        w_state_nxt = S_DONE;
      end
    end else if ((r_state == S_RECEIVING) && valid_in) begin
      if (r_wcnt == CNT_MAX) begin
        w_state_nxt = S_ERROR;
        w_err_nxt   = ERR_OVF;
      end else begin
        w_fold = 1'b1;
      end
    end

    // Values published on finish include the finish-cycle sample when folded.
    w_fin_max = w_fold ? w_upd_max : r_wmax;
    w_fin_min = w_fold ? w_upd_min : r_wmin;
    w_fin_cnt = w_fold ? (r_wcnt + CNT_ONE) : r_wcnt;
  end

  // State, working set and result registers.
  always_ff @(posedge clock) begin
    // NOTE: these are individual flops, not a memory array, so every one takes the reset.
    if (reset) begin
      r_state   <= S_IDLE;
      r_err     <= ERR_NONE;
      r_wmax    <= '0;
      r_wmin    <= '0;
      r_wcnt    <= '0;
      r_max_out <= '0;
      r_min_out <= '0;
      r_range   <= '0;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt == S_RECEIVING);
      r_error <= (w_state_nxt == S_ERROR);
      r_done  <= w_publish;

      if (w_load_first) begin
        r_wmax <= data_in;
        r_wmin <= data_in;
        r_wcnt <= CNT_ONE;
      end else if (w_fold) begin
        r_wmax <= w_upd_max;
        r_wmin <= w_upd_min;
        r_wcnt <= r_wcnt + CNT_ONE;
      end

      if (w_publish) begin
        r_max_out <= w_fin_max;
        r_min_out <= w_fin_min;
        r_range   <= w_fin_max - w_fin_min;  // modulo difference, exact since max >= min
        r_count   <= w_fin_cnt;
      end
    end
  end

  assign max_out  = r_max_out;
  assign min_out  = r_min_out;
  assign range    = r_range;
  assign count    = r_count;
  assign done     = r_done;
  assign busy     = r_busy;
  assign error    = r_error;
  assign err_code = r_err;

endmodule : range_tracker

// File: tb/tb_range_tracker.sv
// Testbench for range_tracker: two instances (8-bit unsigned with a 4-bit
// counter, 8-bit signed with a 2-bit counter) share one stimulus stream and
// are compared every cycle against a sample-list reference model.
module tb_range_tracker;

  logic       clk = 1'b0;
  logic       rst, go, fin, vin;
  logic [7:0] din;

  logic [7:0] u_max, u_min, u_rng;
  logic [3:0] u_cnt;
  logic       u_done, u_busy, u_err;
  logic [1:0] u_code;

  logic [7:0] s_max, s_min, s_rng;
  logic [1:0] s_cnt;
  logic       s_done, s_busy, s_err;
  logic [1:0] s_code;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  range_tracker #(.WIDTH(8), .SIGNED(1'b0), .CNT_WIDTH(4)) dut_u (
    .clock(clk), .reset(rst), .data_in(din), .go(go), .finish(fin), .valid_in(vin),
    .max_out(u_max), .min_out(u_min), .range(u_rng), .count(u_cnt),
    .done(u_done), .busy(u_busy), .error(u_err), .err_code(u_code)
  );

  range_tracker #(.WIDTH(8), .SIGNED(1'b1), .CNT_WIDTH(2)) dut_s (
    .clock(clk), .reset(rst), .data_in(din), .go(go), .finish(fin), .valid_in(vin),
    .max_out(s_max), .min_out(s_min), .range(s_rng), .count(s_cnt),
    .done(s_done), .busy(s_busy), .error(s_err), .err_code(s_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a session is just the list of samples seen so far.
  // Phase: 0 idle, 1 in session, 2 results shown, 3 error.
  int         m_phase[2];
  int         m_n[2];
  int         m_samp[2][16];
  int         m_code[2];
  int         m_cnt_out[2];
  logic [7:0] m_max_out[2], m_min_out[2], m_rng_out[2];
  bit         m_done[2];
  int         cap[2] = '{15, 3};

  function automatic int as_num(input int inst, input logic [7:0] v);
    if (inst == 1 && v[7]) return int'(v) - 256;
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_n[i] = 0; m_code[i] = 0; m_cnt_out[i] = 0;
      m_max_out[i] = '0; m_min_out[i] = '0; m_rng_out[i] = '0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (rst) begin
        m_phase[i] = 0; m_n[i] = 0; m_code[i] = 0; m_cnt_out[i] = 0;
        m_max_out[i] = '0; m_min_out[i] = '0; m_rng_out[i] = '0;
      end else if (go && fin) begin
        m_phase[i] = 3; m_code[i] = 1;
      end else if (go) begin
        m_phase[i] = 1; m_code[i] = 0; m_n[i] = 1; m_samp[i][0] = as_num(i, din);
      end else if (fin) begin
        if (m_phase[i] != 1) begin
          m_phase[i] = 3; m_code[i] = 2;
        end else if (vin && m_n[i] == cap[i]) begin
          m_phase[i] = 3; m_code[i] = 3;
        end else begin
          int mx, mn, diff;
          if (vin) begin m_samp[i][m_n[i]] = as_num(i, din); m_n[i]++; end
          mx = m_samp[i][0]; mn = m_samp[i][0];
          for (int k = 1; k < m_n[i]; k++) begin
            if (m_samp[i][k] > mx) mx = m_samp[i][k];
            if (m_samp[i][k] < mn) mn = m_samp[i][k];
          end
          diff = mx - mn;
          m_max_out[i] = mx[7:0]; m_min_out[i] = mn[7:0]; m_rng_out[i] = diff[7:0];
          m_cnt_out[i] = m_n[i]; m_done[i] = 1'b1; m_phase[i] = 2;
        end
      end else if (m_phase[i] == 1 && vin) begin
        if (m_n[i] == cap[i]) begin
          m_phase[i] = 3; m_code[i] = 3;
        end else begin
          m_samp[i][m_n[i]] = as_num(i, din); m_n[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("u_max",  u_max,  m_max_out[0]);
    check("u_min",  u_min,  m_min_out[0]);
    check("u_rng",  u_rng,  m_rng_out[0]);
    check("u_cnt",  u_cnt,  m_cnt_out[0]);
    check("u_done", u_done, m_done[0]);
    check("u_busy", u_busy, m_phase[0] == 1);
    check("u_err",  u_err,  m_phase[0] == 3);
    check("u_code", u_code, m_code[0]);
    check("s_max",  s_max,  m_max_out[1]);
    check("s_min",  s_min,  m_min_out[1]);
    check("s_rng",  s_rng,  m_rng_out[1]);
    check("s_cnt",  s_cnt,  m_cnt_out[1]);
    check("s_done", s_done, m_done[1]);
    check("s_busy", s_busy, m_phase[1] == 1);
    check("s_err",  s_err,  m_phase[1] == 3);
    check("s_code", s_code, m_code[1]);
  endtask

  // One clock: drive on the falling edge, step the model on the rising edge,
  // and compare just after it.
  task automatic cyc(input bit r, input bit g, input bit f, input bit v, input logic [7:0] d);
    @(negedge clk);
    rst = r; go = g; fin = f; vin = v; din = d;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; fin = 1'b0; vin = 1'b0; din = '0;
    model_reset();

    // Reset state
    cyc(1, 0, 0, 0, 8'd0);
    check("rst_u_busy", u_busy, 0);
    check("rst_u_code", u_code, 0);

    // Unsigned session: 10, 3, 200, finish with 50
    cyc(0, 1, 0, 0, 8'd10);
    cyc(0, 0, 0, 1, 8'd3);
    cyc(0, 0, 0, 1, 8'd200);
    cyc(0, 0, 1, 1, 8'd50);
    check("t1_max",  u_max,  200);
    check("t1_min",  u_min,  3);
    check("t1_rng",  u_rng,  197);
    check("t1_cnt",  u_cnt,  4);
    check("t1_done", u_done, 1);
    cyc(0, 0, 0, 0, 8'd0);
    check("t1_done_fall", u_done, 0);

    // Signed extremes
    cyc(0, 1, 0, 0, 8'h80);
    cyc(0, 0, 0, 1, 8'h7F);
    cyc(0, 0, 1, 0, 8'h00);
    check("t2_max", s_max, 8'h7F);
    check("t2_min", s_min, 8'h80);
    check("t2_rng", s_rng, 8'hFF);
    check("t2_cnt", s_cnt, 2);

    // go&finish from IDLE, recovery, finish outside a session
    cyc(1, 0, 0, 0, 8'd0);
    cyc(0, 1, 1, 0, 8'd0);
    check("t3_err",  u_err,  1);
    check("t3_code", u_code, 1);
    cyc(0, 1, 0, 0, 8'd5);
    cyc(0, 0, 1, 0, 8'd0);
    check("t3_err_clr", u_err, 0);
    check("t3_rng",     u_rng, 0);
    check("t3_cnt",     u_cnt, 1);
    cyc(0, 0, 1, 0, 8'd0);
    check("t3_code2", u_code, 2);
    check("t3_keep_max", u_max, 5);
    check("t3_keep_min", u_min, 5);
    check("t3_keep_cnt", u_cnt, 1);

    // Overflow on the 2-bit counter instance
    cyc(0, 1, 0, 0, 8'd9);
    cyc(0, 0, 0, 1, 8'd1);
    cyc(0, 0, 0, 1, 8'd2);
    check("t4_busy", s_busy, 1);
    cyc(0, 0, 0, 1, 8'd3);
    check("t4_code", s_code, 3);
    check("t4_keep_max", s_max, 5);
    check("t4_keep_cnt", s_cnt, 1);

    // Restart mid-session
    cyc(0, 1, 0, 0, 8'd100);
    cyc(0, 0, 0, 1, 8'd20);
    cyc(0, 1, 0, 1, 8'd50);
    cyc(0, 0, 0, 1, 8'd60);
    cyc(0, 0, 1, 0, 8'd0);
    check("t5_max", u_max, 60);
    check("t5_min", u_min, 50);
    check("t5_rng", u_rng, 10);
    check("t5_cnt", u_cnt, 2);

    // Reset during a session, then finish with no session
    cyc(0, 1, 0, 0, 8'd7);
    cyc(0, 0, 0, 1, 8'd1);
    cyc(1, 0, 1, 1, 8'd3);
    check("t6_max",  u_max,  0);
    check("t6_cnt",  u_cnt,  0);
    check("t6_busy", u_busy, 0);
    cyc(0, 0, 1, 0, 8'd0);
    check("t6_code", u_code, 2);

    // Randomised traffic with boundary-heavy data
    for (int k = 0; k < 3000; k++) begin
      bit r, g, f, v;
      logic [7:0] d;
      int sel;
      r   = ($urandom_range(0, 199) == 0);
      g   = ($urandom_range(0, 99) < 7);
      f   = ($urandom_range(0, 99) < 8);
      v   = ($urandom_range(0, 99) < 60);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       d = 8'h00;
        1:       d = 8'hFF;
        2:       d = 8'h7F;
        3:       d = 8'h80;
        default: d = 8'($urandom);
      endcase
      cyc(r, g, f, v, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_range_tracker

// File: doc/range_tracker.md
# range_tracker

Parametrised successor to the two-bit range finder in the TinyTapeout wrapper. It tracks the minimum and maximum of a session of samples framed by `go` and `finish`, and then presents registered `max_out`, `min_out`, `range` and sample `count` with a one-cycle `done` pulse. Compared with its predecessor it adds signed/unsigned mode, per-cycle sample qualification, session restart, a saturating sample counter with overflow detection, and an encoded error cause. It drops into the wrapper in place of the existing finder, with `WIDTH` sized to the available pins.

## Interface
- `WIDTH`, 16: sample and result width.
- `SIGNED`, 0: 1 = samples compared as two's complement; 0 = unsigned.
- `CNT_WIDTH`, 8: sample counter width; maximum session length is 2^CNT_WIDTH−1 samples.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  sample.
- `go`  in  1  start or restart a session; `data_in` in that cycle is the first sample.
- `finish`  in  1  end the session; `data_in` is included if `valid_in`=1.
- `valid_in`  in  1  qualifies `data_in` during RECEIVING and on `finish`.
- `max_out`, `min_out`  out  WIDTH  extremes of the last completed session.
- `range`  out  WIDTH  `max_out` − `min_out`, unsigned.
- `count`  out  CNT_WIDTH  samples in the last completed session.
- `done`  out  1  one-cycle pulse when the results update.
- `busy`  out  1  state == RECEIVING.
- `error`  out  1  state == ERROR.
- `err_code`  out  2  0 none, 1 go&finish together, 2 finish outside a session, 3 count overflow.

## Operation
- States: IDLE, RECEIVING, DONE, ERROR. All outputs are registered.
- Reset: state IDLE. All outputs are 0. Working max, min and count are 0.
- IDLE, DONE or ERROR with `go`&!`finish`: go to RECEIVING. Working max = min = `data_in` and working count = 1. `err_code` clears to 0.
- RECEIVING with `valid_in`: update the working max and min, and count+1.
- RECEIVING with `go`&!`finish`: restart. The working set is discarded and reloaded from `data_in` with count 1. `valid_in` is ignored in that cycle.
- RECEIVING with `finish`&!`go`: fold in `data_in` if `valid_in`. Load `max_out`, `min_out`, `range` and `count` from the working set. Go to DONE and pulse `done`.
- `go`&`finish` in any state: go to ERROR with code 1. Results are unchanged.
- `finish`&!`go` in IDLE, DONE or ERROR: go to ERROR with code 2. Results are unchanged.
- Overflow: a counted sample when the working count = 2^CNT_WIDTH−1 sends the block to ERROR with code 3. This includes a `valid_in` sample on `finish`. The session is discarded and the results are unchanged.
- ERROR holds, keeping its code, until `go`&!`finish`. A fresh ERROR entry overwrites the code.
- Comparison follows `SIGNED`.
- `range` is computed as the modulo-2^WIDTH difference. It is exact in both modes, because max ≥ min means the difference is in [0, 2^WIDTH−1].
- DONE holds the results indefinitely.

## Timing
- `go` is sampled at edge N. `busy`=1 from edge N.
- `finish` is sampled at edge M. The results update and `done`=1 at edge M, and `done` falls at M+1. `busy`=0 from M.
- Latency from the last sample to the result is one edge.
- Back-to-back sessions are allowed: `go` in the cycle after `finish` starts a new session, and the DONE results stay valid until the next `finish`.
- `reset` asserted mid-session takes priority over every input. All outputs are 0 after that edge.

## Structure
- Package `range_tracker_pkg`: state enum (`state_t`, 2 bits) and error enum (`err_t`: `ERR_NONE`, `ERR_GOFIN`, `ERR_NOSESS`, `ERR_OVF`).
- Sub-module `minmax_update` (combinational, parameters `WIDTH` and `SIGNED`): takes the current max/min and a sample, and returns the next max/min. It is instantiated once and used for both the in-session and the finish-cycle fold.
- The top level holds the FSM, working registers, counter and output registers.

## Test plan
- `WIDTH`=8, unsigned. `go` with 10; `valid_in` samples 3 and 200; `finish` with `valid_in` and 50 → `max_out`=200, `min_out`=3, `range`=197, `count`=4, `done` high exactly one cycle.
- `SIGNED`=1. `go` with 8'h80; valid 8'h7F; `finish` with `valid_in`=0 → `max_out`=8'h7F, `min_out`=8'h80, `range`=8'hFF, `count`=2.
- IDLE with `go`&`finish` → `error`=1, `err_code`=1. Then `go` with 5 and `finish` with `valid_in`=0 → `error`=0, `range`=0, `count`=1. Then `finish` in DONE → `err_code`=2 with results still 0/5/5/1.
- `CNT_WIDTH`=2. `go`, then valid samples 1 and 2 (count 3), then a valid 3rd sample → `err_code`=3 and results unchanged from the prior session.
- Restart: `go` with 100, valid 20, `go` with 50, valid 60, `finish` with `valid_in`=0 → `max_out`=60, `min_out`=50, `range`=10, `count`=2.
- Reset: `reset` asserted during RECEIVING after two samples → next cycle all outputs 0 and state IDLE. A following `finish` gives `err_code`=2.
